// File: rtl/ahb_decode_mux_n.sv
// AHB address decoder and response mux for NUM_SLAVES slaves plus an internal default slave.
// Select is combinational from HADDR; the response mux follows the registered data-phase select.
// Unmapped active transfers get a two-cycle ERROR, and a stalled slave is aborted after TIMEOUT_CYCLES.
//
// Ports:
//   HCLK, HRESETn           clock, async active-low reset
//   HADDR, HTRANS           master address phase
//   HSEL_S                  one-hot slave select (lowest matching index wins)
//   HRDATA_S, HREADYOUT_S,
//   HRESP_S                 per-slave data-phase responses (slave i at [32i+31:32i])
//   HRDATA, HREADY, HRESP   muxed response to master (HREADY also fans out to slaves)
//   timeout_irq             one-cycle pulse while in ABORT1
//   timeout_slave           sticky index of the last timed-out slave
//   err_count               saturating count of ERROR responses generated here
//   err_clear               synchronous clear of err_count and timeout_slave
module ahb_decode_mux_n #(
  parameter int                        NUM_SLAVES     = 8,
  parameter logic [32*NUM_SLAVES-1:0]  SLV_BASE       = (32*NUM_SLAVES)'({
    32'h000F_0000, 32'h000E_0000, 32'h000D_0000, 32'h000C_0000,
    32'h000B_0000, 32'h000A_0000, 32'h0009_0000, 32'h0008_0000,
    32'h0007_0000, 32'h0006_0000, 32'h0005_0000, 32'h0004_0000,
    32'h0003_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000}),
  parameter logic [32*NUM_SLAVES-1:0]  SLV_MASK       = {NUM_SLAVES{32'hFFFF_0000}},
  parameter int                        TIMEOUT_CYCLES = 256,
  parameter logic [31:0]               NOMAP_DATA     = 32'hDEAD_BEEF
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic [31:0]              HADDR,
  input  logic [1:0]               HTRANS,
  output logic [NUM_SLAVES-1:0]    HSEL_S,
  input  logic [32*NUM_SLAVES-1:0] HRDATA_S,
  input  logic [NUM_SLAVES-1:0]    HREADYOUT_S,
  input  logic [NUM_SLAVES-1:0]    HRESP_S,
  output logic [31:0]              HRDATA,
  output logic                     HREADY,
  output logic                     HRESP,
  output logic                     timeout_irq,
  output logic [3:0]               timeout_slave,
  output logic [7:0]               err_count,
  input  logic                     err_clear
);

  // The counter only needs to reach TIMEOUT_CYCLES-1: the abort is taken on
  // the edge where it would have reached the limit.
  localparam int            CW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_NORMAL,
    ST_ERR1,
    ST_ERR2,
    ST_ABORT1,
    ST_ABORT2
  } state_e;

  state_e state_q, state_d;

  logic          addr_hit;
  logic [3:0]    addr_idx;
  logic          addr_err;

  logic          dp_mapped_q, dp_mapped_d;
  logic [3:0]    dp_idx_q,    dp_idx_d;
  logic          dp_trans_q,  dp_trans_d;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    tslave_q, tslave_d;
  logic [7:0]    errcnt_q, errcnt_d;

  logic [31:0]   slv_rdata;
  logic          slv_rdy;
  logic          slv_resp;
  logic          hready;
  logic          waiting;
  logic          abort_hit;

  // IDLE and BUSY behave identically here; only HTRANS[1] matters.
  logic          unused_htrans0;
  assign unused_htrans0 = HTRANS[0];

  // ---------------------------------------------------------------------------
  // Address decode: scan from the top so the lowest matching index wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    addr_hit = 1'b0;
    addr_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((HADDR & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
        addr_hit = 1'b1;
        addr_idx = 4'(i);
      end
    end
  end

  always_comb begin
    HSEL_S = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      HSEL_S[i] = addr_hit && (addr_idx == 4'(i));
    end
  end

  assign addr_err = !addr_hit && HTRANS[1];

  // ---------------------------------------------------------------------------
  // Data-phase slave mux
  // ---------------------------------------------------------------------------
  always_comb begin
    slv_rdata = '0;
    slv_rdy   = 1'b1;
    slv_resp  = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (dp_idx_q == 4'(i)) begin
        slv_rdata = HRDATA_S[32*i +: 32];
        slv_rdy   = HREADYOUT_S[i];
        slv_resp  = HRESP_S[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= ST_NORMAL;
    else          state_q <= state_d;
  end

  // Only an active transfer waiting on a mapped slave counts toward the
  // timeout; slaves must answer IDLE/BUSY with zero wait states anyway.
  assign waiting   = (state_q == ST_NORMAL) && dp_mapped_q && dp_trans_q && !slv_rdy;
  assign abort_hit = (TIMEOUT_CYCLES != 0) && waiting && (cnt_q == TO_LIM);

  // ---------------------------------------------------------------------------
  // Response FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_NORMAL: begin
        if (hready && addr_err) state_d = ST_ERR1;
        else if (abort_hit)     state_d = ST_ABORT1;
      end
      ST_ERR1:   state_d = ST_ERR2;
      ST_ABORT1: state_d = ST_ABORT2;
      // HREADY is high here, so a new address phase is accepted as usual.
      ST_ERR2, ST_ABORT2: state_d = addr_err ? ST_ERR1 : ST_NORMAL;
      default:   state_d = ST_NORMAL;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Response FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    HRDATA = NOMAP_DATA;
    hready = 1'b1;
    HRESP  = 1'b0;
    case (state_q)
      ST_NORMAL: begin
        if (dp_mapped_q) begin
          HRDATA = slv_rdata;
          hready = slv_rdy;
          HRESP  = slv_resp;
        end
      end
      ST_ERR1, ST_ABORT1: begin
        hready = 1'b0;
        HRESP  = 1'b1;
      end
      ST_ERR2, ST_ABORT2: begin
        hready = 1'b1;
        HRESP  = 1'b1;
      end
      default: ;
    endcase
  end

  assign HREADY      = hready;
  assign timeout_irq = (state_q == ST_ABORT1);

  // ---------------------------------------------------------------------------
  // Data-phase select, timeout counter, error bookkeeping
  // ---------------------------------------------------------------------------
  always_comb begin
    dp_mapped_d = dp_mapped_q;
    dp_idx_d    = dp_idx_q;
    dp_trans_d  = dp_trans_q;
    if (hready) begin
      dp_mapped_d = addr_hit;
      dp_idx_d    = addr_idx;
      dp_trans_d  = HTRANS[1];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (hready)       cnt_d = '0;
    else if (waiting) cnt_d = cnt_q + 1'b1;
  end

  // Every transition into ERR1/ABORT1 is an entry (neither state self-loops).
  always_comb begin
    errcnt_d = errcnt_q;
    tslave_d = tslave_q;
    if (err_clear) begin
      errcnt_d = '0;
      tslave_d = '0;
    end else begin
      if (((state_d == ST_ERR1) || (state_d == ST_ABORT1)) && (errcnt_q != 8'hFF))
        errcnt_d = errcnt_q + 8'd1;
      if (state_d == ST_ABORT1)
        tslave_d = dp_idx_q;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_mapped_q <= 1'b0;
      dp_idx_q    <= '0;
      dp_trans_q  <= 1'b0;
      cnt_q       <= '0;
      tslave_q    <= '0;
      errcnt_q    <= '0;
    end else begin
      dp_mapped_q <= dp_mapped_d;
      dp_idx_q    <= dp_idx_d;
      dp_trans_q  <= dp_trans_d;
      cnt_q       <= cnt_d;
      tslave_q    <= tslave_d;
      errcnt_q    <= errcnt_d;
    end
  end

  assign timeout_slave = tslave_q;
  assign err_count     = errcnt_q;

endmodule
